// File: rtl/up_sampling_nx_pkg.sv
// up_sampling_nx_pkg: output FSM states and sizing helpers for the upsampler.
package up_sampling_nx_pkg;
  typedef enum logic [1:0] {IDLE, EMIT, LAST} state_e;
  function automatic int row_words(input int string_len, input int channel_num);
    return string_len * channel_num;
  endfunction
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/up_sampling_line_ram.sv
// up_sampling_line_ram: simple dual-port RAM, one write port and a 1-clock registered read.
module up_sampling_line_ram #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**AW];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/up_sampling_nx.sv
// up_sampling_nx: SCALE x SCALE nearest-neighbour upsampler of a channel-interleaved
// row stream, buffering rows in two ping-pong banks of one line RAM.
module up_sampling_nx
  import up_sampling_nx_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int STRING_LEN  = 7,
  parameter int CHANNEL_NUM = 256,
  parameter int SCALE       = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_valid_i,
  input  logic                  sop_i,
  input  logic                  eop_i,
  input  logic                  sof_i,
  input  logic                  eof_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_o,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic                  sof_o,
  output logic                  eof_o,
  output logic                  err_len_o,
  output logic                  err_ovf_o
);
  localparam int RW  = row_words(STRING_LEN, CHANNEL_NUM);
  localparam int OW  = cnt_width(RW);
  localparam int CW  = cnt_width(RW + 2);
  localparam int CHW = cnt_width(CHANNEL_NUM);
  localparam int HW  = cnt_width(SCALE);
  localparam logic [CW-1:0]  ROW_LEN    = CW'(RW);
  localparam logic [OW-1:0]  OFF_MAX    = OW'(RW - 1);
  localparam logic [OW-1:0]  PIX_REWIND = OW'(CHANNEL_NUM - 1);
  localparam logic [CHW-1:0] CH_MAX     = CHW'(CHANNEL_NUM - 1);
  localparam logic [HW-1:0]  REP_MAX    = HW'(SCALE - 1);

  state_e          state_q;
  logic            rd_bank_q, wr_bank_q, wr_act_q, wr_sof_q;
  logic [1:0]      full_q, sof_flag_q, eof_flag_q;
  logic [CW-1:0]   wr_cnt_q, wr_pos, wr_cnt_d;
  logic [OW-1:0]   off_q, off_d;
  logic [CHW-1:0]  ch_q, ch_d;
  logic [HW-1:0]   hr_q, hr_d, vr_q, vr_d;
  logic            bank_free, in_row, wr_en, wr_done, wr_sof_val, release_b;
  logic            ch_last, hr_last, vr_last, row_end, last_rd, start, rd_en, cur_sof;
  logic            rd_vld_q, rd_sop_q, rd_eop_q, rd_sof_q, rd_eof_q;
  logic [DATA_WIDTH-1:0] rd_data;

  // In LAST the final read of ~rd_bank_q has already been issued, so that bank is free.
  assign release_b  = state_q == LAST;
  assign bank_free  = !full_q[wr_bank_q] || (release_b && wr_bank_q != rd_bank_q);
  assign wr_pos     = sop_i ? '0 : wr_cnt_q;
  assign in_row     = data_valid_i && (sop_i ? bank_free : wr_act_q);
  assign wr_en      = in_row && wr_pos < ROW_LEN;
  assign wr_cnt_d   = (wr_pos > ROW_LEN) ? wr_pos : wr_pos + 1'b1;
  assign wr_done    = in_row && eop_i && wr_cnt_d == ROW_LEN;
  assign wr_sof_val = sop_i ? sof_i : wr_sof_q;

  up_sampling_line_ram #(.DW(DATA_WIDTH), .AW(OW + 1)) u_ram (
    .clk    (clk),
    .we_i   (wr_en),
    .waddr_i({wr_bank_q, wr_pos[OW-1:0]}),
    .wdata_i(data_i),
    .raddr_i({rd_bank_q, off_q}),
    .rdata_o(rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_act_q   <= 1'b0;
      wr_cnt_q   <= '0;
      wr_bank_q  <= 1'b0;
      wr_sof_q   <= 1'b0;
      full_q     <= '0;
      sof_flag_q <= '0;
      eof_flag_q <= '0;
      err_len_o  <= 1'b0;
      err_ovf_o  <= 1'b0;
    end else begin
      if (data_valid_i && (sop_i || wr_act_q)) begin
        wr_act_q <= in_row && !eop_i;
        wr_cnt_q <= wr_cnt_d;
      end
      if (data_valid_i && sop_i) wr_sof_q <= sof_i;
      if (data_valid_i && ((sop_i && wr_act_q) || (in_row && eop_i && !wr_done))) err_len_o <= 1'b1;
      if (data_valid_i && sop_i && !bank_free) err_ovf_o <= 1'b1;
      if (release_b) full_q[!rd_bank_q] <= 1'b0;
      if (wr_done) begin
        wr_bank_q             <= !wr_bank_q;
        full_q[wr_bank_q]     <= 1'b1;
        sof_flag_q[wr_bank_q] <= wr_sof_val;
        eof_flag_q[wr_bank_q] <= eof_i;
      end
    end
  end

  // A row completing during LAST is started at once so the banks stream back-to-back.
  assign start   = (state_q == IDLE && full_q[rd_bank_q]) ||
                   (state_q == LAST && (full_q[rd_bank_q] || (wr_done && wr_bank_q == rd_bank_q)));
  assign rd_en   = start || state_q == EMIT;
  assign cur_sof = full_q[rd_bank_q] ? sof_flag_q[rd_bank_q] : wr_sof_val;

  always_comb begin
    ch_last = ch_q == CH_MAX;
    hr_last = hr_q == REP_MAX;
    vr_last = vr_q == REP_MAX;
    row_end = off_q == OFF_MAX;
    last_rd = hr_last && row_end && vr_last;
    ch_d    = ch_last ? '0 : ch_q + 1'b1;
    hr_d    = !ch_last ? hr_q : hr_last ? '0 : hr_q + 1'b1;
    off_d   = (!ch_last || (hr_last && !row_end)) ? off_q + 1'b1 : !hr_last ? off_q - PIX_REWIND : '0;
    vr_d    = (hr_last && row_end) ? (vr_last ? '0 : vr_q + 1'b1) : vr_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rd_bank_q    <= 1'b0;
      off_q        <= '0;
      ch_q         <= '0;
      hr_q         <= '0;
      vr_q         <= '0;
      rd_vld_q     <= 1'b0;
      rd_sop_q     <= 1'b0;
      rd_eop_q     <= 1'b0;
      rd_sof_q     <= 1'b0;
      rd_eof_q     <= 1'b0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      sop_o        <= 1'b0;
      eop_o        <= 1'b0;
      sof_o        <= 1'b0;
      eof_o        <= 1'b0;
    end else begin
      state_q <= !rd_en ? IDLE : last_rd ? LAST : EMIT;
      if (rd_en) begin
        off_q <= off_d;
        ch_q  <= ch_d;
        hr_q  <= hr_d;
        vr_q  <= vr_d;
        if (last_rd) rd_bank_q <= !rd_bank_q;
      end
      rd_vld_q     <= rd_en;
      rd_sop_q     <= rd_en && off_q == '0 && hr_q == '0;
      rd_eop_q     <= rd_en && row_end && hr_last;
      rd_sof_q     <= rd_en && off_q == '0 && hr_q == '0 && vr_q == '0 && cur_sof;
      rd_eof_q     <= rd_en && last_rd && eof_flag_q[rd_bank_q];
      data_o       <= rd_vld_q ? rd_data : '0;
      data_valid_o <= rd_vld_q;
      sop_o        <= rd_sop_q;
      eop_o        <= rd_eop_q;
      sof_o        <= rd_sof_q;
      eof_o        <= rd_eof_q;
    end
  end
endmodule

// File: tb/tb_up_sampling_nx.sv
// tb_up_sampling_nx: directed checks of the upsampler (SCALE=2) and a SCALE=1 build.
module tb_up_sampling_nx;
  logic       clk = 0, reset_n = 0;
  logic [7:0] data_i = '0;
  logic       vin = 0, sel1 = 0, sop_i = 0, eop_i = 0, sof_i = 0, eof_i = 0;
  logic       v0, v1;
  logic [7:0] d0, d1;
  logic       dv0, sop0, eop0, sof0, eof0, el0, eo0;
  logic       dv1, sop1, eop1, sof1, eof1, el1, eo1;
  int         cyc = 0, checks = 0, errors = 0, eop_cyc = 0;
  typedef struct packed { logic [11:0] w; int cyc; } obs_t;
  obs_t q0[$], q1[$];
  int ord [16] = '{0, 1, 0, 1, 2, 3, 2, 3, 0, 1, 0, 1, 2, 3, 2, 3};

  assign v0 = vin & ~sel1;
  assign v1 = vin & sel1;

  up_sampling_nx #(.DATA_WIDTH(8), .STRING_LEN(2), .CHANNEL_NUM(2), .SCALE(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .data_i(data_i), .data_valid_i(v0),
    .sop_i(sop_i), .eop_i(eop_i), .sof_i(sof_i), .eof_i(eof_i),
    .data_o(d0), .data_valid_o(dv0), .sop_o(sop0), .eop_o(eop0), .sof_o(sof0), .eof_o(eof0),
    .err_len_o(el0), .err_ovf_o(eo0)
  );

  up_sampling_nx #(.DATA_WIDTH(8), .STRING_LEN(2), .CHANNEL_NUM(2), .SCALE(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .data_i(data_i), .data_valid_i(v1),
    .sop_i(sop_i), .eop_i(eop_i), .sof_i(sof_i), .eof_i(eof_i),
    .data_o(d1), .data_valid_o(dv1), .sop_o(sop1), .eop_o(eop1), .sof_o(sof1), .eof_o(eof1),
    .err_len_o(el1), .err_ovf_o(eo1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (dv0) q0.push_back('{w: {d0, sop0, eop0, sof0, eof0}, cyc: cyc});
    if (dv1) q1.push_back('{w: {d1, sop1, eop1, sof1, eof1}, cyc: cyc});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input bit s, input bit e, input bit sf, input bit ef);
    data_i = d; vin = 1; sop_i = s; eop_i = e; sof_i = sf; eof_i = ef;
    @(negedge clk);
    if (e) eop_cyc = cyc;
  endtask

  task automatic idle(input int n);
    vin = 0; sop_i = 0; eop_i = 0; sof_i = 0; eof_i = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_row(input logic [7:0] b, input bit sf, input bit ef);
    send(b, 1, 0, sf, 0);
    send(b + 8'd1, 0, 0, 0, 0);
    send(b + 8'd2, 0, 0, 0, 0);
    send(b + 8'd3, 0, 1, 0, ef);
  endtask

  task automatic check_row(input string tag, input int at, input logic [7:0] b, input bit sf, input bit ef);
    for (int i = 0; i < 16; i++) begin
      logic [11:0] got, exp;
      got = (at + i < q0.size()) ? q0[at+i].w : 12'hfff;
      exp = {b + 8'(ord[i]), i == 0 || i == 8, i == 7 || i == 15, sf && i == 0, ef && i == 15};
      check($sformatf("%s_w%0d", tag, i), 32'(got), 32'(exp));
    end
  endtask

  function automatic int span(input int n);
    return (q0.size() >= n) ? q0[n-1].cyc - q0[0].cyc : -1;
  endfunction

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_dut", {d0, dv0, sop0, eop0, sof0, eof0, el0, eo0}, 0);
    check("rst_dut1", {d1, dv1, sop1, eop1, sof1, eof1, el1, eo1}, 0);
    reset_n = 1;
    idle(2);
    send_row(8'h01, 1, 1);
    idle(24);
    check("t1_count", q0.size(), 16);
    check("t1_latency", (q0.size() > 0) ? q0[0].cyc - eop_cyc : -1, 2);
    check("t1_span", span(16), 15);
    check_row("t1", 0, 8'h01, 1, 1);
    q0.delete();
    send_row(8'h05, 1, 0);
    idle(13);
    send_row(8'h09, 0, 1);
    idle(40);
    check("t2_count", q0.size(), 32);
    check("t2_span", span(32), 31);
    check_row("t2a", 0, 8'h05, 1, 0);
    check_row("t2b", 16, 8'h09, 0, 1);
    check("t2_errs", {el0, eo0}, 0);
    q0.delete();
    send_row(8'h31, 1, 0);
    send_row(8'h41, 0, 0);
    send_row(8'h51, 0, 1);
    idle(45);
    check("t3_count", q0.size(), 32);
    check("t3_span", span(32), 31);
    check_row("t3a", 0, 8'h31, 1, 0);
    check_row("t3b", 16, 8'h41, 0, 0);
    check("t3_errs", {el0, eo0}, 2'b01);
    q0.delete();
    send(8'h61, 1, 0, 1, 0);
    send(8'h62, 0, 0, 0, 0);
    send(8'h63, 0, 1, 0, 0);
    idle(10);
    check("t4_no_out", q0.size(), 0);
    check("t4_errs", {el0, eo0}, 2'b11);
    send_row(8'h71, 1, 1);
    idle(24);
    check("t4_count", q0.size(), 16);
    check_row("t4", 0, 8'h71, 1, 1);
    q0.delete();
    send_row(8'h81, 1, 1);
    idle(0);
    for (int k = 0; k < 40 && q0.size() < 5; k++) begin
      @(negedge clk);
      #1;
    end
    check("t5_word5", q0.size(), 5);
    reset_n = 0;
    @(negedge clk);
    check("t5_rst_outs", {d0, dv0, sop0, eop0, sof0, eof0, el0, eo0}, 0);
    @(negedge clk);
    reset_n = 1;
    idle(6);
    check("t5_stopped", q0.size(), 5);
    q0.delete();
    send_row(8'h91, 1, 1);
    idle(24);
    check("t5_count", q0.size(), 16);
    check_row("t5", 0, 8'h91, 1, 1);
    q0.delete();
    sel1 = 1;
    send_row(8'h01, 1, 1);
    idle(12);
    check("t6_count", q1.size(), 4);
    check("t6_latency", (q1.size() > 0) ? q1[0].cyc - eop_cyc : -1, 2);
    check("t6_dut_quiet", q0.size(), 0);
    for (int i = 0; i < 4; i++)
      check($sformatf("t6_w%0d", i), (i < q1.size()) ? 32'(q1[i].w) : 32'hfff,
            32'({8'(i + 1), i == 0, i == 3, i == 0, i == 3}));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
